// File: rtl/alu_carry_combiner.sv
// Nibble-serial carry resolver: chains carry across p/g nibbles, emits sum nibbles plus final flags.
// Optional feature macro: ALU_CC_ZERO_FLAG_EN (builds the whole-result zero accumulator).
module alu_carry_combiner #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cin,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] p,
    input  logic [3:0] g,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sum,
    output logic       out_last,
    output logic       cout,
    output logic       ovf,
    output logic       zero,
    output logic       busy
);

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic               carry;
    logic               start_idle;
    logic               accept;
    logic               out_fire;
    logic               last_acc;
    logic [NIB_W:0]     c;
    logic [NIB_W-1:0]   s;

    assign start_idle = start && (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_acc   = accept && (count == CNT_W'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                 state_nxt = RUN;
            RUN:     if (last_acc)              state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last)  state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; single-entry output buffer may refill in the cycle it drains
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (state == RUN) begin
            in_ready = !out_valid || out_ready;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Ripple carry across the four bits of the accepted nibble
    always_comb begin
        c    = '0;
        c[0] = carry;
        for (int i = 0; i < NIB_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = p ^ c[NIB_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry     <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (start_idle) begin
            carry <= cin;
            count <= '0;
        end else if (accept) begin
            carry     <= c[NIB_W];
            count     <= count + CNT_W'(1);
            sum       <= s;
            out_valid <= 1'b1;
            out_last  <= last_acc;
            cout      <= last_acc & c[NIB_W];
            ovf       <= last_acc & (c[NIB_W-1] ^ c[NIB_W]);
        end else if (out_fire) begin
            out_valid <= 1'b0;
            if (state == DRAIN) begin
                count <= '0;
            end
        end
    end

`ifdef ALU_CC_ZERO_FLAG_EN
    logic zero_acc;

    // Tracks whether every sum nibble so far has been zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (start_idle) begin
            zero_acc <= 1'b1;
        end else if (accept) begin
            zero_acc <= zero_acc & (s == '0);
            zero     <= last_acc & zero_acc & (s == '0);
        end
    end
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_carry_combiner.sv
// Self-checking bench for alu_carry_combiner: directed and random add/sub ops against an arithmetic model.
module tb_alu_carry_combiner;

    localparam int unsigned NIB = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cin;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] p;
    logic [3:0] g;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum;
    logic       out_last;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       busy;

    int errors = 0;
    int checks = 0;

    alu_carry_combiner #(.NIBBLES(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_last  (out_last),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: always ready; 1: 3-cycle stall on first sum; 2: random valid/ready
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input int mode, input bit inject);
        logic [16:0] res;
        logic [3:0]  exp_s [NIB];
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
        int          ni;
        int          no;
        int          cyc;
        int          stall;
        int          idx;
        int          first_acc;
        int          first_out;
        int          last_out;
        bit          stalled;

        res = {1'b0, a} + {1'b0, b} + 17'(ci);
        for (int k = 0; k < NIB; k++) exp_s[k] = res[4*k +: 4];
        exp_c = res[16];
        exp_v = (a[15] == b[15]) && (res[15] != a[15]);
`ifdef ALU_CC_ZERO_FLAG_EN
        exp_z = (res[15:0] == 16'h0);
`else
        exp_z = 1'b0;
`endif
        start = 1'b1;
        cin   = ci;
        @(posedge clk); #1;
        start = 1'b0;
        cin   = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        ni = 0; no = 0; cyc = 0; stall = 0; stalled = 0;
        first_acc = -1; first_out = -1; last_out = -1;
        while (no < NIB && cyc < 200) begin
            idx      = (ni < NIB) ? ni : 0;
            in_valid = (ni < NIB) && (mode != 2 || $urandom_range(0, 1) == 1);
            p        = a[4*idx +: 4] ^ b[4*idx +: 4];
            g        = a[4*idx +: 4] & b[4*idx +: 4];
            if (mode == 1 && !stalled && out_valid) begin
                stall   = 3;
                stalled = 1;
            end
            out_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : (stall == 0);
            if (stall > 0) stall--;
            start = inject && (cyc == 1);
            cin   = inject && (cyc == 1);
            #1;
            if (out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    check("first_sum_latency", 32'(first_out), 32'(first_acc + 1));
                end
                check("sum", 32'(sum), 32'(exp_s[no]));
                check("out_last", 32'(out_last), 32'(no == NIB - 1));
                check("cout", 32'(cout), (no == NIB - 1) ? 32'(exp_c) : 32'd0);
                check("ovf", 32'(ovf), (no == NIB - 1) ? 32'(exp_v) : 32'd0);
                check("zero", 32'(zero), (no == NIB - 1) ? 32'(exp_z) : 32'd0);
                if (!out_ready) begin
                    check("in_ready_hold", 32'(in_ready), 32'd0);
                end else begin
                    if (mode == 0 && no > 0) check("consecutive", 32'(cyc), 32'(last_out + 1));
                    last_out = cyc;
                    no++;
                end
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                ni++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        cin      = 1'b0;
        check("op_done", 32'(no), 32'(NIB));
        check("busy_idle", 32'(busy), 32'd0);
        check("out_valid_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p         = '0;
        g         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_flags", {28'd0, sum}, 32'd0);
        check("rst_last_cout_ovf_zero", {28'd0, out_last, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0);
        run_op(16'h0005, ~16'h0005, 1'b1, 0, 0);
        run_op(16'h1234, 16'h0FFF, 1'b0, 1, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1);

        // Abort after two accepted nibbles
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        p        = 4'hA;
        g        = 4'h5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'hABCD, 16'h1111, 1'b0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
